// File: rtl/cnt_timer_ctrl.sv
// Command-driven sequencer for a prescaled up counter: accepts a terminal count over
// valid/ready, runs one-shot or periodic, and supports pause and abort.
module cnt_timer_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_tc,
    input  logic             cmd_periodic,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [PW-1:0]     prescaler;
    logic [WIDTH-1:0]  tc_q;
    logic              per_q;
    logic [WIDTH-1:0]  count_inc;

    assign count_inc = count + CNT_ONE;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            tc_q      <= '0;
            per_q     <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here; a pending command always starts
                    if (cmd_valid) begin
                        tc_q      <= cmd_tc;
                        per_q     <= cmd_periodic;
                        count     <= '0;
                        prescaler <= '0;
                        if (cmd_tc == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN, PAUSE: begin
                    if (abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else begin
                        state <= RUN;
                        if (prescaler == PS_LAST) begin
                            prescaler <= '0;
                            // terminal count: periodic restarts from zero, one-shot parks at TC
                            if (count_inc == tc_q) begin
                                done <= 1'b1;
                                if (per_q) begin
                                    count <= '0;
                                end else begin
                                    count <= tc_q;
                                    state <= DONE;
                                end
                            end else begin
                                count <= count_inc;
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
